// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the handshaked pipeline-register family
// (IF/ID, ID/EX, EX/MEM).
//   skid_state_t    : occupancy state of a two-entry skid stage; the encoding
//                     equals the number of held entries.
//   PIPE_NOP        : default bubble instruction.
//   skid_occupancy  : state -> entry count.
// ----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    localparam logic [31:0] PIPE_NOP = 32'h0000_0000;

    // The state encoding is chosen so the count is the state value itself;
    // keeping the mapping here lets every stage share it.
    function automatic logic [1:0] skid_occupancy(input skid_state_t s);
        return logic'(s[1]) ? 2'd2 : {1'b0, s[0]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating event counter used for per-stage stall statistics.
//   clock      : rising-edge clock
//   startin_n  : asynchronous active-low reset, clears the count
//   inc        : count this cycle
//   count      : current count, sticks at all-ones
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             startin_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE_LSB = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE_LSB;
    endfunction

    always_ff @(posedge clock or negedge startin_n) begin
        if (!startin_n) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// ----------------------------------------------------------------------------
// if_id_skid_stage
// Fetch-to-decode pipeline register with a two-entry skid buffer. Fetch may
// issue one more entry after decode stalls; in_ready is registered so there
// is no combinational ready path back into fetch. flush kills all held
// entries and presents a NOP bubble. All outputs come directly from flops.
//
// Ports
//   clock          : rising-edge clock
//   startin_n      : asynchronous active-low reset
//   in_valid       : fetch offers an entry
//   in_ready       : stage can accept (registered)
//   in_instr       : fetched instruction
//   in_pc_plus_4   : PC+4 of the fetched instruction
//   flush          : synchronous kill of all held entries
//   out_valid      : decode entry valid
//   out_ready      : decoder accepts
//   out_instr      : instruction to decode (NOP_INSTR when not valid)
//   out_pc_plus_4  : PC+4 to decode
//   occupancy      : held entries, 0..2
//   stall_cycles   : saturating count of back-pressure cycles
// ----------------------------------------------------------------------------
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(PIPE_NOP),
    parameter int                 CNT_W     = 16
) (
    input  logic               clock,
    input  logic               startin_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc_plus_4,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc_plus_4,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cycles
);

    skid_state_t state_q, state_d;

    logic               main_vld_p1;
    logic               skid_vld_p1;
    logic [INSTR_W-1:0] main_instr_p1;
    logic [PC_W-1:0]    main_pc_p1;
    logic [INSTR_W-1:0] skid_instr_p1;
    logic [PC_W-1:0]    skid_pc_p1;

    logic in_xfer;
    logic out_xfer;
    logic load_main_in;
    logic load_main_skid;
    logic load_main_nop;
    logic load_skid_in;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_vld_p1 && out_ready;

    // ------------------------------------------------------------------
    // Next-state and slot-load decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_main_nop  = 1'b0;
        load_skid_in   = 1'b0;

        if (flush) begin
            // Any handshake in this cycle is discarded.
            state_d       = EMPTY;
            load_main_nop = 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        load_main_in = 1'b1;
                        state_d      = ONE;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        load_main_in = 1'b1;
                    end else if (out_xfer) begin
                        load_main_nop = 1'b1;
                        state_d       = EMPTY;
                    end else if (in_xfer) begin
                        load_skid_in = 1'b1;
                        state_d      = FULL;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain can happen.
                    if (out_xfer && skid_vld_p1) begin
                        load_main_skid = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: begin
                    state_d       = EMPTY;
                    load_main_nop = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge startin_n) begin
        if (!startin_n) begin
            state_q     <= EMPTY;
            main_vld_p1 <= 1'b0;
            skid_vld_p1 <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_vld_p1 <= (state_d != EMPTY);
            skid_vld_p1 <= (state_d == FULL);
            // Registered from the next state so fetch sees no combinational
            // path through this stage.
            in_ready    <= (state_d != FULL);
        end
    end

    // ------------------------------------------------------------------
    // Stage p1: slot payload registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge startin_n) begin
        if (!startin_n) begin
            main_instr_p1 <= NOP_INSTR;
            main_pc_p1    <= '0;
            skid_instr_p1 <= '0;
            skid_pc_p1    <= '0;
        end else begin
            // The PC field is left untouched on a bubble; only the
            // instruction is forced to NOP.
            if (load_main_nop) begin
                main_instr_p1 <= NOP_INSTR;
            end else if (load_main_skid) begin
                main_instr_p1 <= skid_instr_p1;
                main_pc_p1    <= skid_pc_p1;
            end else if (load_main_in) begin
                main_instr_p1 <= in_instr;
                main_pc_p1    <= in_pc_plus_4;
            end

            if (load_skid_in) begin
                skid_instr_p1 <= in_instr;
                skid_pc_p1    <= in_pc_plus_4;
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clock     (clock),
        .startin_n (startin_n),
        .inc       (main_vld_p1 && !out_ready),
        .count     (stall_cycles)
    );

    assign out_valid     = main_vld_p1;
    assign out_instr     = main_instr_p1;
    assign out_pc_plus_4 = main_pc_p1;
    assign occupancy     = skid_occupancy(state_q);

endmodule

// File: tb/tb_if_id_skid_stage.sv
module tb_if_id_skid_stage;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        startin_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc_plus_4 = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_instr, out_pc_plus_4;
    logic [1:0]  occupancy;
    logic [15:0] stall_cycles;

    logic        in_ready4, out_valid4;
    logic [31:0] out_instr4, out_pc4;
    logic [1:0]  occupancy4;
    logic [3:0]  stall4;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    if_id_skid_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(16)) dut (
        .clock(clock), .startin_n(startin_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc_plus_4(in_pc_plus_4),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc_plus_4(out_pc_plus_4),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    if_id_skid_stage #(.INSTR_W(INSTR_W), .PC_W(PC_W), .NOP_INSTR(NOP), .CNT_W(4)) dut4 (
        .clock(clock), .startin_n(startin_n),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_instr(in_instr), .in_pc_plus_4(in_pc_plus_4),
        .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_instr(out_instr4), .out_pc_plus_4(out_pc4),
        .occupancy(occupancy4), .stall_cycles(stall4)
    );

    // Reference model: an in-order FIFO of held entries, capacity two.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_head_pc;
    logic        m_rdy;
    int          m_stall;
    int          m_stall4;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_head_pc = '0;
        m_rdy     = 1'b1;
        m_stall   = 0;
        m_stall4  = 0;
    endtask

    task automatic check_all();
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("out_instr", 64'(out_instr), 64'((q.size() > 0) ? q[0].instr : NOP));
        check("out_pc", 64'(out_pc_plus_4), 64'(m_head_pc));
        check("in_ready", 64'(in_ready), 64'(m_rdy));
        check("occupancy", 64'(occupancy), 64'(q.size()));
        check("stall16", 64'(stall_cycles), 64'(m_stall));
        check("stall4", 64'(stall4), 64'(m_stall4));
    endtask

    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic in_x, out_x, st;
        ent_t e;
        in_valid     = iv;
        in_instr     = ins;
        in_pc_plus_4 = pc;
        out_ready    = ordy;
        flush        = fl;
        in_x  = iv && m_rdy;
        out_x = (q.size() > 0) && ordy;
        st    = (q.size() > 0) && !ordy;
        @(posedge clock);
        #1;
        if (st) begin
            if (m_stall < 65535) m_stall++;
            if (m_stall4 < 15) m_stall4++;
        end
        if (fl) begin
            q.delete();
        end else begin
            if (out_x) void'(q.pop_front());
            if (in_x) begin
                e.instr = ins;
                e.pc    = pc;
                q.push_back(e);
            end
        end
        if (q.size() > 0) m_head_pc = q[0].pc;
        m_rdy = (q.size() < 2);
        check_all();
    endtask

    task automatic apply_reset();
        startin_n = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        startin_n = 1'b1;
        model_reset();
    endtask

    initial begin
        model_reset();
        apply_reset();

        // Reset state
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_instr", 64'(out_instr), 64'(NOP));
        check("rst_out_pc", 64'(out_pc_plus_4), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_occupancy", 64'(occupancy), 64'(0));
        check("rst_stall", 64'(stall_cycles), 64'(0));

        // Streaming A0..A9 with out_ready held high
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'hA000_0000 + 32'(i), 32'(4 * (i + 1)), 1'b1, 1'b0);
            check("stream_instr", 64'(out_instr), 64'(32'hA000_0000 + 32'(i)));
            check("stream_occ", 64'(occupancy), 64'(1));
        end
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("stream_stall", 64'(stall_cycles), 64'(0));

        // Back-pressure: out_ready low for three cycles while fetch keeps offering
        apply_reset();
        step(1'b1, 32'hB000_0000, 32'h100, 1'b1, 1'b0);
        step(1'b1, 32'hB000_0001, 32'h104, 1'b0, 1'b0);
        check("bp_in_ready_fall", 64'(in_ready), 64'(0));
        step(1'b1, 32'hB000_0002, 32'h108, 1'b0, 1'b0);
        step(1'b1, 32'hB000_0002, 32'h108, 1'b0, 1'b0);
        check("bp_occ", 64'(occupancy), 64'(2));
        check("bp_stall", 64'(stall_cycles), 64'(3));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_skid_out", 64'(out_instr), 64'(32'hB000_0001));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("bp_drained", 64'(out_valid), 64'(0));

        // Flush while FULL with an entry on offer
        apply_reset();
        step(1'b1, 32'hC000_0000, 32'h200, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0001, 32'h204, 1'b0, 1'b0);
        step(1'b1, 32'hC000_0002, 32'h208, 1'b1, 1'b1);
        check("fl_valid", 64'(out_valid), 64'(0));
        check("fl_instr", 64'(out_instr), 64'(NOP));
        check("fl_occ", 64'(occupancy), 64'(0));
        check("fl_ready", 64'(in_ready), 64'(1));
        check("fl_pc_held", 64'(out_pc_plus_4), 64'(32'h200));
        step(1'b0, '0, '0, 1'b1, 1'b0);
        check("fl_not_delivered", 64'(out_valid), 64'(0));

        // Saturation of the narrow counter: 20 back-pressure cycles
        apply_reset();
        step(1'b1, 32'hD000_0000, 32'h300, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
        check("sat_stall4", 64'(stall4), 64'(15));
        check("sat_stall16", 64'(stall_cycles), 64'(20));

        // Asynchronous reset while FULL
        apply_reset();
        step(1'b1, 32'hE000_0000, 32'h400, 1'b0, 1'b0);
        step(1'b1, 32'hE000_0001, 32'h404, 1'b0, 1'b0);
        check("pre_async_occ", 64'(occupancy), 64'(2));
        #2;
        startin_n = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'(0));
        check("async_instr", 64'(out_instr), 64'(NOP));
        check("async_pc", 64'(out_pc_plus_4), 64'(0));
        check("async_ready", 64'(in_ready), 64'(1));
        check("async_occ", 64'(occupancy), 64'(0));
        check("async_stall", 64'(stall_cycles), 64'(0));
        @(posedge clock);
        #1;
        startin_n = 1'b1;
        model_reset();
        step(1'b0, '0, '0, 1'b0, 1'b0);
        check("post_async_ready", 64'(in_ready), 64'(1));
        check("post_async_occ", 64'(occupancy), 64'(0));

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom, $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised successor to the IF/ID pipeline register: a valid/ready handshaked fetch-to-decode stage with a two-entry skid buffer, synchronous flush with NOP bubble insertion, and a saturating back-pressure counter. It sits between the fetch unit and the decoder. Fetch can keep issuing for one extra cycle after decode stalls without losing an instruction. The registered `in_ready` breaks the combinational ready path back into fetch.

## Interface
- `INSTR_W`, 32, instruction width in bits
- `PC_W`, 32, width of the PC+4 field
- `NOP_INSTR`, 32'h0000_0000, instruction value presented while the stage holds no valid entry; width INSTR_W
- `CNT_W`, 16, width of the stall counter

- `clock`  in  1  single clock, rising edge
- `startin_n`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  fetch offers an entry
- `in_ready`  out  1  stage can accept; registered
- `in_instr`  in  INSTR_W  fetched instruction
- `in_pc_plus_4`  in  PC_W  PC+4 of the fetched instruction
- `flush`  in  1  synchronous kill of all held entries (branch/jump redirect)
- `out_valid`  out  1  decode entry valid
- `out_ready`  in  1  decoder accepts
- `out_instr`  out  INSTR_W  instruction to decode
- `out_pc_plus_4`  out  PC_W  PC+4 to decode
- `occupancy`  out  2  held entries, 0..2
- `stall_cycles`  out  CNT_W  count of back-pressure cycles

## Operation
- Storage:
  - main slot, which drives the `out_*` ports
  - skid slot
  - each slot has a valid bit
- States:
  - EMPTY: no valid slot
  - ONE: main valid
  - FULL: main and skid valid
- An input transfer occurs when `in_valid && in_ready`. An output transfer occurs when `out_valid && out_ready`.
- EMPTY: input transfer loads main and moves to ONE.
- ONE:
  - in + out transfer: main loads the input; stay in ONE.
  - out only: move to EMPTY.
  - in only: skid loads the input; move to FULL.
  - neither: hold.
- FULL:
  - `in_ready` = 0.
  - out transfer: main loads skid; move to ONE.
  - otherwise hold.
- `in_ready` = 1 in EMPTY and ONE, 0 in FULL. It is computed from next state and registered.
- `flush`:
  - Highest priority.
  - Next state is EMPTY. Both valids clear.
  - Main `instr` loads NOP_INSTR and main `pc_plus_4` holds its value.
  - Any input or output handshake in the flush cycle is discarded. The decoder must ignore the out transfer.
- Whenever main is invalid, `out_instr` = NOP_INSTR. Main `instr` also loads NOP_INSTR on the ONE→EMPTY drain.
- Entries leave in arrival order. No entry is duplicated or dropped except by flush.
- `occupancy` = 0/1/2 for EMPTY/ONE/FULL.
- `stall_cycles`:
  - Increments each cycle `out_valid && !out_ready`, including the cycle flush is asserted.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.

## Timing
- Reset values:
  - `out_valid` 0
  - `out_instr` NOP_INSTR
  - `out_pc_plus_4` 0
  - `in_ready` 1
  - `occupancy` 0
  - `stall_cycles` 0
  - skid contents 0
  - state EMPTY
- Reset mid-operation discards all held entries asynchronously.
- Latency: an input accepted at edge N appears on `out_*` after edge N (one cycle) when the stage is EMPTY or draining in ONE.
- Throughput: one entry per cycle sustained while `out_ready` = 1.
- After `out_ready` deasserts, at most one further input is accepted (into skid). `in_ready` falls on the following edge.
- No combinational path from any input to any output. All outputs come straight from flops.

## Structure
- Shared package `pipe_pkg`:
  - state enum `skid_state_t` with EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2
  - default NOP constant `PIPE_NOP`, reused by the later ID/EX and EX/MEM successors
- One sub-module `sat_counter`:
  - parameter CNT_W
  - ports: `clock`, `startin_n`, `inc`, `count`
  - reused for other stages' stall statistics

## Test plan
- Reset asserted mid-FULL: all outputs return to reset values immediately, without waiting for a clock edge. After release, `in_ready` = 1 and `occupancy` = 0.
- Streaming, `out_ready` held 1: entries A0..A9 with `in_pc_plus_4` 4,8,..,40 emerge in order one cycle after entry. `occupancy` stays 1 and `stall_cycles` stays 0.
- `out_ready` low for 3 cycles while `in_valid` is high:
  - Exactly one extra entry is accepted and `in_ready` falls the next cycle.
  - `occupancy` = 2 and `stall_cycles` = 3.
  - On release, main then skid emerge back-to-back, in order.
- `flush` in FULL with `in_valid` = 1:
  - Next cycle `out_valid` = 0, `out_instr` = NOP_INSTR, `occupancy` = 0, `in_ready` = 1.
  - The offered entry is not delivered.
- `stall_cycles` with CNT_W = 4: 20 back-pressure cycles give `stall_cycles` = 15 (saturates and holds).
